ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_ram_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// ram_ctrl: bridges a single-beat MEM-stage request onto an asynchronous
// SRAM with a split data bus. One access at a time; all SRAM strobes and
// the completion pulse are registered so they change only on clock edges
// (or immediately on reset).
//
// Handshake: the MEM stage raises mem_ce_i together with we/addr/sel/data.
// The request is captured on the first rising edge seen in IDLE; later
// changes to any request input are ignored until the controller is back in
// IDLE. Completion is a single-cycle mem_ready_o pulse, with mem_data_o
// already valid for reads in that cycle. After the pulse the controller
// waits in RELEASE until mem_ce_i is seen low, so a request left asserted
// can never start a second access.
module ram_ctrl #(
  parameter int READ_WAIT = 2,  // read strobe cycles before capture, 1..15
  parameter int WE_PULSE  = 1   // write-enable low cycles, 1..15
) (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active-low
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready_o,
  output logic [19:0] sram_addr_o,
  output logic [31:0] sram_dq_o,
  input  logic [31:0] sram_dq_i,
  output logic        sram_dq_oe_o,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o,
  output logic [3:0]  sram_be_n_o,
  output logic [2:0]  dbg_state_o   // current FSM state, for observation
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    W_SETUP = 3'd2,
    W_PULSE = 3'd3,
    W_HOLD  = 3'd4,
    DONE    = 3'd5,
    RELEASE = 3'd6
  } state_t;

  // Counter reload values: the counter runs down to zero, and the state
  // leaves on the edge where it reads zero.
  localparam logic [3:0] RD_LAST = 4'(READ_WAIT - 1);
  localparam logic [3:0] WE_LAST = 4'(WE_PULSE - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [3:0]  r_sel;
  logic [19:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_ready;
  logic        r_ce_n;
  logic        r_oe_n;
  logic        r_we_n;
  logic        r_dq_oe;
  logic [3:0]  r_be_n;

  logic [31:0] w_lane_mask;
  logic        w_unused;

  // Byte-lane mask used to zero unselected lanes of captured read data.
  assign w_lane_mask = {{8{r_sel[3]}}, {8{r_sel[2]}},
                        {8{r_sel[1]}}, {8{r_sel[0]}}};

  // Only address bits [21:2] select a word; the rest are don't-care.
  assign w_unused = ^{mem_addr_i[31:22], mem_addr_i[1:0]};

  // FSM, request latch, counter and all registered outputs. Every branch
  // drives the strobe values for the state being entered, so outputs line
  // up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_sel   <= 4'd0;
      r_addr  <= 20'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_ready <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_dq_oe <= 1'b0;
      r_be_n  <= 4'hF;
    end else begin
      // Idle values; states that need a strobe override them below.
      r_ready <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_dq_oe <= 1'b0;
      r_be_n  <= 4'hF;

      case (r_state)
        IDLE: begin
          if (mem_ce_i) begin
            r_addr  <= mem_addr_i[21:2];
            r_sel   <= mem_sel_i;
            r_wdata <= mem_data_i;
            if (mem_sel_i == 4'd0) begin
              // Nothing to transfer: complete without touching the SRAM.
              r_state <= DONE;
              r_ready <= 1'b1;
              if (!mem_we_i) begin
                r_rdata <= 32'd0;
              end
            end else if (!mem_we_i) begin
              r_state <= READ;
              r_cnt   <= RD_LAST;
              r_ce_n  <= 1'b0;
              r_oe_n  <= 1'b0;
              r_be_n  <= ~mem_sel_i;
            end else begin
              r_state <= W_SETUP;
              r_ce_n  <= 1'b0;
              r_dq_oe <= 1'b1;
              r_be_n  <= ~mem_sel_i;
            end
          end
        end

        READ: begin
          if (r_cnt == 4'd0) begin
            r_rdata <= sram_dq_i & w_lane_mask;
            r_state <= DONE;
            r_ready <= 1'b1;
          end else begin
            r_cnt  <= r_cnt - 4'd1;
            r_ce_n <= 1'b0;
            r_oe_n <= 1'b0;
            r_be_n <= ~r_sel;
          end
        end

        W_SETUP: begin
          r_state <= W_PULSE;
          r_cnt   <= WE_LAST;
          r_ce_n  <= 1'b0;
          r_we_n  <= 1'b0;
          r_dq_oe <= 1'b1;
          r_be_n  <= ~r_sel;
        end

        W_PULSE: begin
          r_ce_n  <= 1'b0;
          r_dq_oe <= 1'b1;
          r_be_n  <= ~r_sel;
          if (r_cnt == 4'd0) begin
            // Raise we_n while data is still driven: one cycle of hold.
            r_state <= W_HOLD;
          end else begin
            r_cnt  <= r_cnt - 4'd1;
            r_we_n <= 1'b0;
          end
        end

        W_HOLD: begin
          r_state <= DONE;
          r_ready <= 1'b1;
        end

        DONE: begin
          r_state <= RELEASE;
        end

        RELEASE: begin
          // Wait for the requester to drop its request before re-arming.
          if (!mem_ce_i) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_data_o   = r_rdata;
  assign mem_ready_o  = r_ready;
  assign sram_addr_o  = r_addr;
  assign sram_dq_o    = r_wdata;
  assign sram_dq_oe_o = r_dq_oe;
  assign sram_ce_n_o  = r_ce_n;
  assign sram_oe_n_o  = r_oe_n;
  assign sram_we_n_o  = r_we_n;
  assign sram_be_n_o  = r_be_n;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: SRAM behavioural model, request driver, scoreboard
// monitor with expected queues and a final report.
module tb_ram_ctrl;
  localparam int RW = 2;
  localparam int WP = 1;

  logic        clk;
  logic        rst;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_ready_o;
  logic [19:0] sram_addr_o;
  logic [31:0] sram_dq_o;
  logic [31:0] sram_dq_i;
  logic        sram_dq_oe_o;
  logic        sram_ce_n_o;
  logic        sram_oe_n_o;
  logic        sram_we_n_o;
  logic [3:0]  sram_be_n_o;
  logic [2:0]  dbg_state_o;

  ram_ctrl #(.READ_WAIT(RW), .WE_PULSE(WP)) dut (
    .clk(clk), .rst(rst),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i),
    .mem_data_o(mem_data_o), .mem_ready_o(mem_ready_o),
    .sram_addr_o(sram_addr_o), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe_o(sram_dq_oe_o), .sram_ce_n_o(sram_ce_n_o),
    .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o),
    .sram_be_n_o(sram_be_n_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- SRAM model (environment) ----------------
  logic [31:0] sram_mem [0:1023];
  always_comb begin
    sram_dq_i = 32'h5A5A_5A5A;
    if (!sram_ce_n_o && !sram_oe_n_o) sram_dq_i = sram_mem[sram_addr_o[9:0]];
  end
  always @(posedge clk) begin
    if (rst && !sram_ce_n_o && !sram_we_n_o && sram_dq_oe_o) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n_o[b]) sram_mem[sram_addr_o[9:0]][8*b +: 8] <= sram_dq_o[8*b +: 8];
    end
  end

  // ---------------- reference model + scoreboard queues ----------------
  logic [31:0] ref_mem [0:1023];
  logic [31:0] model_data;         // what mem_data_o should hold
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  int          exp_oe_q[$];
  int          exp_we_q[$];
  // expected SRAM-side view of the access in flight
  logic [19:0] cur_word;
  logic [3:0]  cur_sel;
  logic [31:0] cur_data;
  logic [31:0] held;

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = s[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  // ---------------- monitor ----------------
  int oe_cnt = 0;
  int we_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      oe_cnt = 0;
      we_cnt = 0;
    end else begin
      if (!sram_oe_n_o) oe_cnt++;
      if (!sram_we_n_o) we_cnt++;
      // strobe legality and address/data/lane checks every cycle
      if (sram_ce_n_o) begin
        check("idle_strobes", {26'd0, sram_oe_n_o, sram_we_n_o, sram_be_n_o},
              {26'd0, 1'b1, 1'b1, 4'hF});
        check("idle_dq_oe", {31'd0, sram_dq_oe_o}, 32'd0);
      end else begin
        check("sram_addr", {12'd0, sram_addr_o}, {12'd0, cur_word});
        check("sram_be_n", {28'd0, sram_be_n_o}, {28'd0, ~cur_sel});
        if (!sram_oe_n_o) check("read_no_drive", {31'd0, sram_dq_oe_o}, 32'd0);
        if (!sram_we_n_o) check("we_needs_oe", {31'd0, sram_dq_oe_o}, 32'd1);
        if (sram_dq_oe_o) check("sram_dq_o", sram_dq_o, cur_data);
      end
      if (mem_ready_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 32'd1, 32'd0);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("ready_data", mem_data_o, e);
          check("ready_cycle", cyc, exp_cyc_q.pop_front());
          check("oe_cycles", oe_cnt, exp_oe_q.pop_front());
          check("we_cycles", we_cnt, exp_we_q.pop_front());
          check("idle_in_done", {31'd0, sram_ce_n_o}, 32'd1);
          held = e;
        end
        oe_cnt = 0;
        we_cnt = 0;
      end else begin
        check("data_hold", mem_data_o, held);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_access(input logic we, input logic [31:0] addr,
                           input logic [3:0] sel, input logic [31:0] data,
                           input int hold_extra, input logic drop_early);
    int issue;
    int lat;
    int n_oe;
    int n_we;
    logic [19:0] w;
    @(negedge clk);
    w = addr[21:2];
    cur_word = w; cur_sel = sel; cur_data = data;
    mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr;
    mem_sel_i = sel; mem_data_i = data;
    issue = cyc;
    n_oe = 0; n_we = 0;
    if (sel == 4'd0) begin
      lat = 1;
      if (!we) model_data = 32'd0;
    end else if (!we) begin
      lat = RW + 1; n_oe = RW;
      model_data = ref_mem[w[9:0]] & lane_mask(sel);
    end else begin
      lat = WP + 3; n_we = WP;
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[w[9:0]][8*b +: 8] = data[8*b +: 8];
    end
    exp_q.push_back(model_data);
    exp_cyc_q.push_back(issue + lat);
    exp_oe_q.push_back(n_oe);
    exp_we_q.push_back(n_we);
    @(negedge clk);
    // garbage on the request inputs after the latch must be ignored
    mem_we_i = 1'($urandom); mem_addr_i = $urandom;
    mem_sel_i = 4'($urandom); mem_data_i = $urandom;
    if (drop_early) mem_ce_i = 1'b0;
    while (cyc < issue + lat + 1) @(negedge clk);
    repeat (hold_extra) @(negedge clk);
    mem_ce_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] = $urandom;
      ref_mem[i]  = sram_mem[i];
    end
    sram_mem[10'h123] = 32'hA1B2_C3D4;
    ref_mem[10'h123]  = 32'hA1B2_C3D4;
    model_data = 32'd0; held = 32'd0;
    cur_word = 20'd0; cur_sel = 4'd0; cur_data = 32'd0;
    rst = 1'b0; mem_ce_i = 1'b0; mem_we_i = 1'b0;
    mem_addr_i = 32'd0; mem_sel_i = 4'd0; mem_data_i = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, mem_ready_o}, 32'd0);
    check("rst_data", mem_data_o, 32'd0);
    check("rst_addr", {12'd0, sram_addr_o}, 32'd0);
    check("rst_dq_o", sram_dq_o, 32'd0);
    check("rst_strobes", {24'd0, sram_dq_oe_o, sram_ce_n_o, sram_oe_n_o,
          sram_we_n_o, sram_be_n_o}, {24'd0, 1'b0, 3'b111, 4'hF});
    rst = 1'b1;

    // directed: full-word read, byte read, partial write, held request, sel=0
    do_access(1'b0, 32'h0000_048C, 4'b1111, 32'h0, 0, 1'b0);
    do_access(1'b0, 32'hFFC0_048F, 4'b0100, 32'h0, 0, 1'b0);
    do_access(1'b1, 32'h0000_0010, 4'b0011, 32'hDEAD_BEEF, 0, 1'b0);
    do_access(1'b0, 32'h0000_0010, 4'b1111, 32'h0, 0, 1'b0);
    do_access(1'b0, 32'h0000_048C, 4'b1111, 32'h0, 8, 1'b0);
    do_access(1'b1, 32'h0000_0020, 4'b0000, 32'h1234_5678, 0, 1'b0);
    do_access(1'b0, 32'h0000_0020, 4'b0000, 32'h0, 0, 1'b0);
    do_access(1'b1, 32'h0000_0030, 4'b1001, 32'hCAFE_F00D, 0, 1'b1);

    // reset in the middle of the write-enable pulse
    @(negedge clk);
    cur_word = 20'h00005; cur_sel = 4'hF; cur_data = 32'h0BAD_0BAD;
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_0014;
    mem_sel_i = 4'hF; mem_data_i = 32'h0BAD_0BAD;
    @(negedge clk);
    @(posedge clk);
    #2;
    check("pulse_active", {31'd0, sram_we_n_o}, 32'd0);
    rst = 1'b0;
    #1;
    check("async_we_n", {31'd0, sram_we_n_o}, 32'd1);
    check("async_dq_oe", {31'd0, sram_dq_oe_o}, 32'd0);
    check("async_ce_n", {31'd0, sram_ce_n_o}, 32'd1);
    check("async_data", mem_data_o, 32'd0);
    model_data = 32'd0; held = 32'd0;
    mem_ce_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_access(1'b1, 32'h0000_0014, 4'b1111, 32'h600D_600D, 0, 1'b0);
    do_access(1'b0, 32'h0000_0014, 4'b1111, 32'h0, 0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = {10'($urandom), 10'd0, 10'($urandom_range(0, 1023)), 2'($urandom)};
      do_access(1'($urandom), a, 4'($urandom_range(0, 15)), $urandom,
                $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    check("pending_expect", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
